// File: rtl/mux_scan_pkg.sv
// ---------------------------------------------------------------------------
// mux_scan_pkg
// Shared definitions for the mux select scanner:
//   - state_e          : scanner FSM state encoding
//   - NUM_CH / CH_W    : number of mux inputs and select width
//   - DWELL_W_DEFAULT  : default width of the per-channel dwell count
//   - lowest_set()     : index of the lowest set bit of a channel mask
// ---------------------------------------------------------------------------
package mux_scan_pkg;

    localparam int NUM_CH          = 4;
    localparam int CH_W            = 2;
    localparam int DWELL_W_DEFAULT = 4;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SCAN     = 2'd1,
        WAIT_RDY = 2'd2
    } state_e;

    // Walking from the top bit down means the last hit is the lowest set bit.
    // An empty mask yields 0, which callers never rely on.
    function automatic logic [CH_W-1:0] lowest_set(input logic [NUM_CH-1:0] mask);
        logic [CH_W-1:0] idx;
        idx = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (mask[i]) begin
                idx = CH_W'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_next_ch.sv
// ---------------------------------------------------------------------------
// rr_next_ch
// Purely combinational round-robin helper for the scanner. Given the latched
// channel mask and the current select, it returns the next enabled channel
// above sel (wrapping to the lowest enabled channel) and flags when sel is the
// highest enabled channel, i.e. the last channel of the frame.
//
// Ports:
//   mask     in  [NUM_CH-1:0]  enabled channels of the current frame
//   sel      in  [CH_W-1:0]    channel currently selected
//   next_sel out [CH_W-1:0]    next enabled channel, wrapping
//   last     out               no enabled channel exists above sel
// ---------------------------------------------------------------------------
module rr_next_ch
    import mux_scan_pkg::*;
(
    input  logic [NUM_CH-1:0] mask,
    input  logic [CH_W-1:0]   sel,
    output logic [CH_W-1:0]   next_sel,
    output logic              last
);

    // Start from the wrapped answer, then let any enabled channel above sel
    // override it. Scanning downward leaves the closest channel above sel.
    always_comb begin
        next_sel = lowest_set(mask);
        last     = 1'b1;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (mask[i] && (i > int'(sel))) begin
                next_sel = CH_W'(i);
                last     = 1'b0;
            end
        end
    end

endmodule

// File: rtl/mux_sel_scanner.sv
// ---------------------------------------------------------------------------
// mux_sel_scanner
// Steps a 4:1 analog/digital mux through the enabled channels of ch_en. Each
// channel is held for max(dwell,1) settle cycles; when the count expires a
// one-cycle sample_stb tells downstream to latch the mux output, stalling in
// WAIT_RDY while ready is low. frame_done marks the sample of the highest
// enabled channel. In continuous mode the frame restarts with a fresh ch_en.
//
// Ports:
//   clk         in                 single clock, rising edge
//   rst_n       in                 asynchronous active-low reset
//   start       in                 begin a frame (IDLE only)
//   stop        in                 abort, return to IDLE (highest priority)
//   cont        in                 1 = restart frames automatically
//   ch_en       in  [3:0]          channel enable mask
//   dwell       in  [DWELL_W-1:0]  settle cycles per channel, 0 acts as 1
//   ready       in                 downstream can take a sample
//   sel         out [1:0]          registered mux select
//   sel_valid   out                registered, scanning active
//   sample_stb  out                combinational sample strobe
//   frame_done  out                combinational, last sample of a frame
//   busy        out                registered, not IDLE
// ---------------------------------------------------------------------------
module mux_sel_scanner
    import mux_scan_pkg::*;
#(
    parameter int DWELL_W = DWELL_W_DEFAULT
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               stop,
    input  logic               cont,
    input  logic [NUM_CH-1:0]  ch_en,
    input  logic [DWELL_W-1:0] dwell,
    input  logic               ready,
    output logic [CH_W-1:0]    sel,
    output logic               sel_valid,
    output logic               sample_stb,
    output logic               frame_done,
    output logic               busy
);

    state_e              state_q, state_d;
    logic [CH_W-1:0]     sel_q, sel_d;
    logic [DWELL_W-1:0]  cnt_q, cnt_d;
    logic [NUM_CH-1:0]   mask_q, mask_d;
    logic                busy_q, busy_d;

    logic [CH_W-1:0]     next_sel;
    logic                last_ch;
    logic [DWELL_W-1:0]  reload_val;
    logic                take_sample;

    rr_next_ch u_rr_next_ch (
        .mask     (mask_q),
        .sel      (sel_q),
        .next_sel (next_sel),
        .last     (last_ch)
    );

    // cnt counts remaining settle cycles minus one, so a dwell of 0 or 1 both
    // expire in the first cycle on the channel.
    assign reload_val = (dwell == '0) ? '0 : (dwell - DWELL_W'(1));

    // Next-state logic. The case only decides whether a sample is taken this
    // cycle; the shared advance step below then picks the next channel, the
    // frame restart, or the return to IDLE. stop overrides everything.
    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        cnt_d       = cnt_q;
        mask_d      = mask_q;
        take_sample = 1'b0;

        if (stop) begin
            state_d = IDLE;
            sel_d   = '0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start && (ch_en != '0)) begin
                        state_d = SCAN;
                        mask_d  = ch_en;
                        sel_d   = lowest_set(ch_en);
                        cnt_d   = reload_val;
                    end
                end
                SCAN: begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - DWELL_W'(1);
                    end else if (ready) begin
                        take_sample = 1'b1;
                    end else begin
                        state_d = WAIT_RDY;
                    end
                end
                WAIT_RDY: begin
                    if (ready) begin
                        take_sample = 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    sel_d   = '0;
                    cnt_d   = '0;
                end
            endcase

            if (take_sample) begin
                if (!last_ch) begin
                    state_d = SCAN;
                    sel_d   = next_sel;
                    cnt_d   = reload_val;
                end else if (cont && (ch_en != '0)) begin
                    state_d = SCAN;
                    mask_d  = ch_en;
                    sel_d   = lowest_set(ch_en);
                    cnt_d   = reload_val;
                end else begin
                    state_d = IDLE;
                    sel_d   = '0;
                    cnt_d   = '0;
                end
            end
        end

        busy_d = (state_d != IDLE);
    end

    // State registers. busy_q tracks state_d so busy/sel_valid come straight
    // from a flop rather than from a decode of state_q.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sel_q   <= '0;
            cnt_q   <= '0;
            mask_q  <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
            mask_q  <= mask_d;
            busy_q  <= busy_d;
        end
    end

    assign sel        = sel_q;
    assign sel_valid  = busy_q;
    assign busy       = busy_q;
    assign sample_stb = take_sample;
    assign frame_done = take_sample & last_ch;

endmodule

// File: tb/tb_mux_sel_scanner.sv
// ---------------------------------------------------------------------------
// tb_mux_sel_scanner
// Directed bench for mux_sel_scanner. A list-based model of the scan (frame =
// queue of enabled channel numbers, a position and a remaining-cycle count) is
// compared against the DUT on every falling edge, and hand-computed literal
// expectations pin the model on the key scenarios.
// ---------------------------------------------------------------------------
module tb_mux_sel_scanner;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       cont = 1'b0;
    logic [3:0] ch_en = 4'b0;
    logic [3:0] dwell = 4'd0;
    logic       ready = 1'b0;
    logic [1:0] sel;
    logic       sel_valid;
    logic       sample_stb;
    logic       frame_done;
    logic       busy;

    int errors = 0;
    int checks = 0;
    bit cmp_en = 1'b0;

    // Model state: enabled channels of the frame, current position, cycles
    // left on the current channel (1 means expiring / waiting for ready).
    int m_chans[$];
    int m_pos = 0;
    int m_rem = 0;
    bit m_active = 1'b0;

    int t1_sel[6] = '{0, 0, 1, 1, 3, 3};
    int t1_stb[6] = '{0, 1, 0, 1, 0, 1};
    int t1_fd[6]  = '{0, 0, 0, 0, 0, 1};
    logic [31:0] rdy_pat = 32'hB3D5_6E19;

    mux_sel_scanner #(.DWELL_W(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .stop       (stop),
        .cont       (cont),
        .ch_en      (ch_en),
        .dwell      (dwell),
        .ready      (ready),
        .sel        (sel),
        .sel_valid  (sel_valid),
        .sample_stb (sample_stb),
        .frame_done (frame_done),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Single comparison primitive shared by the literal checks and the model
    // compare process.
    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s at %0t: actual=%0h expected=%0h", name, $time, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic s_stop, input logic s_start, input logic s_cont,
                                 input logic [3:0] s_en, input logic [3:0] s_dwell, input logic s_ready);
        stop  = s_stop;
        start = s_start;
        cont  = s_cont;
        ch_en = s_en;
        dwell = s_dwell;
        ready = s_ready;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    function automatic int effDwell(input logic [3:0] d);
        return (d == 4'd0) ? 1 : int'(d);
    endfunction

    task automatic beginFrame(input logic [3:0] en);
        m_chans.delete();
        for (int i = 0; i < 4; i++) begin
            if (en[i]) m_chans.push_back(i);
        end
        m_pos    = 0;
        m_rem    = effDwell(dwell);
        m_active = 1'b1;
    endtask

    // Behavioural model: advances on each clock, cleared by reset at once.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_active = 1'b0;
            m_chans.delete();
        end else if (stop) begin
            m_active = 1'b0;
        end else if (!m_active) begin
            if (start && (ch_en != 4'b0)) beginFrame(ch_en);
        end else if (m_rem > 1) begin
            m_rem--;
        end else if (ready) begin
            if (m_pos < m_chans.size() - 1) begin
                m_pos++;
                m_rem = effDwell(dwell);
            end else if (cont && (ch_en != 4'b0)) begin
                beginFrame(ch_en);
            end else begin
                m_active = 1'b0;
            end
        end
    end

    // Compare process: every falling edge, DUT outputs against the model.
    always @(negedge clk) begin
        if (cmp_en) begin
            logic       e_stb;
            logic       e_fd;
            logic [1:0] e_sel;
            e_sel = m_active ? 2'(m_chans[m_pos]) : 2'd0;
            e_stb = m_active && !stop && (m_rem == 1) && ready;
            e_fd  = e_stb && (m_pos == m_chans.size() - 1);
            checkOutput("model_busy", busy, m_active);
            checkOutput("model_sel_valid", sel_valid, m_active);
            checkOutput("model_sel", sel, e_sel);
            checkOutput("model_stb", sample_stb, e_stb);
            checkOutput("model_frame_done", frame_done, e_fd);
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // Reset
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_busy", busy, 1'b0);
        checkOutput("reset_sel", sel, 2'd0);
        checkOutput("reset_stb", sample_stb, 1'b0);
        rst_n  = 1'b1;
        cmp_en = 1'b1;
        nextCycle();

        // Mask 1011, dwell 2, single frame
        applyStimulus(0, 1, 0, 4'b1011, 4'd2, 1);
        @(negedge clk);
        nextCycle();
        start = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            checkOutput("t1_sel", sel, t1_sel[k-1]);
            checkOutput("t1_stb", sample_stb, t1_stb[k-1]);
            checkOutput("t1_fd", frame_done, t1_fd[k-1]);
        end
        @(negedge clk);
        checkOutput("t1_idle_busy", busy, 1'b0);
        nextCycle();

        // Single channel 2, dwell 0, continuous
        applyStimulus(0, 1, 1, 4'b0100, 4'd0, 1);
        @(negedge clk);
        nextCycle();
        start = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            checkOutput("t2_sel", sel, 2'd2);
            checkOutput("t2_stb", sample_stb, 1'b1);
            checkOutput("t2_fd", frame_done, 1'b1);
            nextCycle();
        end
        stop = 1'b1;
        @(negedge clk);
        checkOutput("t2_stop_stb", sample_stb, 1'b0);
        nextCycle();
        stop = 1'b0;
        @(negedge clk);
        checkOutput("t2_stop_busy", busy, 1'b0);
        checkOutput("t2_stop_sel", sel, 2'd0);
        nextCycle();

        // Mask 0011, dwell 1, ready low for 3 cycles at channel 0 expiry
        applyStimulus(0, 1, 0, 4'b0011, 4'd1, 0);
        @(negedge clk);
        nextCycle();
        start = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            checkOutput("t3_wait_sel", sel, 2'd0);
            checkOutput("t3_wait_stb", sample_stb, 1'b0);
            checkOutput("t3_wait_busy", busy, 1'b1);
            nextCycle();
        end
        ready = 1'b1;
        @(negedge clk);
        checkOutput("t3_rdy_stb", sample_stb, 1'b1);
        checkOutput("t3_rdy_sel", sel, 2'd0);
        checkOutput("t3_rdy_fd", frame_done, 1'b0);
        nextCycle();
        @(negedge clk);
        checkOutput("t3_ch1_sel", sel, 2'd1);
        checkOutput("t3_ch1_fd", frame_done, 1'b1);
        nextCycle();
        @(negedge clk);
        checkOutput("t3_idle_busy", busy, 1'b0);
        nextCycle();

        // stop + start together at the expiring cycle of channel 1
        applyStimulus(0, 1, 1, 4'b1111, 4'd3, 1);
        @(negedge clk);
        nextCycle();
        start = 1'b0;
        repeat (5) nextCycle();
        stop  = 1'b1;
        start = 1'b1;
        @(negedge clk);
        checkOutput("t4_stop_sel", sel, 2'd1);
        checkOutput("t4_stop_stb", sample_stb, 1'b0);
        checkOutput("t4_stop_fd", frame_done, 1'b0);
        nextCycle();
        stop  = 1'b0;
        start = 1'b0;
        @(negedge clk);
        checkOutput("t4_idle_busy", busy, 1'b0);
        checkOutput("t4_idle_sel", sel, 2'd0);
        nextCycle();
        applyStimulus(0, 1, 1, 4'b1000, 4'd1, 1);
        @(negedge clk);
        nextCycle();
        start = 1'b0;
        @(negedge clk);
        checkOutput("t4_ch3_sel", sel, 2'd3);
        checkOutput("t4_ch3_fd", frame_done, 1'b1);
        nextCycle();
        stop = 1'b1;
        nextCycle();
        stop = 1'b0;

        // Asynchronous reset mid-scan
        applyStimulus(0, 1, 1, 4'b0110, 4'd4, 1);
        @(negedge clk);
        nextCycle();
        start = 1'b0;
        repeat (2) nextCycle();
        #2 rst_n = 1'b0;
        #1;
        checkOutput("t5_rst_busy", busy, 1'b0);
        checkOutput("t5_rst_sel_valid", sel_valid, 1'b0);
        checkOutput("t5_rst_sel", sel, 2'd0);
        checkOutput("t5_rst_stb", sample_stb, 1'b0);
        checkOutput("t5_rst_fd", frame_done, 1'b0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checkOutput("t5_post_stb", sample_stb, 1'b0);
            checkOutput("t5_post_busy", busy, 1'b0);
        end
        nextCycle();
        applyStimulus(0, 1, 1, 4'b0000, 4'd2, 1);
        @(negedge clk);
        nextCycle();
        start = 1'b0;
        @(negedge clk);
        checkOutput("t5_empty_busy", busy, 1'b0);
        nextCycle();

        // Continuous mode with ch_en cleared before the frame ends
        applyStimulus(0, 1, 1, 4'b1001, 4'd1, 1);
        @(negedge clk);
        nextCycle();
        start = 1'b0;
        @(negedge clk);
        checkOutput("t6_ch0_sel", sel, 2'd0);
        nextCycle();
        ch_en = 4'b0000;
        @(negedge clk);
        checkOutput("t6_ch3_sel", sel, 2'd3);
        checkOutput("t6_ch3_fd", frame_done, 1'b1);
        nextCycle();
        @(negedge clk);
        checkOutput("t6_idle_busy", busy, 1'b0);
        nextCycle();

        // Continuous scan with a fixed ready pattern and a dwell change
        applyStimulus(0, 1, 1, 4'b1101, 4'd2, 1);
        nextCycle();
        start = 1'b0;
        for (int k = 0; k < 32; k++) begin
            ready = rdy_pat[k];
            if (k == 16) dwell = 4'd0;
            if (k == 24) ch_en = 4'b0110;
            nextCycle();
        end
        stop = 1'b1;
        nextCycle();
        stop = 1'b0;
        repeat (2) nextCycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
